// File: rtl/phy_mdio_init.sv
// phy_mdio_init: power-up sequencer for an RGMII Ethernet PHY.
//
// Holds the PHY in hardware reset, releases it, waits for the PHY to settle, then
// shifts a fixed table of Clause-22 MDIO write frames out on MDC/MDIO. When the last
// frame is sent, phy_init_done goes high and stays high; it gates the Ethernet core
// reset downstream. Write-only: there is no turnaround read and no MDIO input.
//
// Ports
//   clock          in   system clock
//   reset          in   asynchronous active-high reset
//   restart        in   1-clock pulse; reruns the whole sequence, honoured only in DONE
//   phy_resetn     out  PHY hardware reset, active low
//   mdio_scl       out  MDC
//   mdio_sda       out  MDIO data, always driven, idles high
//   phy_init_done  out  level, high once every table entry has been written
//
// All outputs come straight from flops.

module phy_mdio_init #(
  parameter int unsigned RESET_CYCLES      = 250000,
  parameter int unsigned POST_RESET_CYCLES = 2500000,
  parameter int unsigned MDC_DIV           = 16,
  parameter int unsigned IDLE_BITS         = 8,
  parameter logic [4:0]  PHY_ADDR          = 5'd0,
  parameter int unsigned NUM_WRITES        = 2,
  // Packed {REGAD[4:0], DATA[15:0]} per entry, entry 0 in the LSBs.
  parameter logic [NUM_WRITES*21-1:0] INIT_TABLE = {21'h0_1140, 21'h1F_0000}
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic phy_resetn,
  output logic mdio_scl,
  output logic mdio_sda,
  output logic phy_init_done
);

  localparam int unsigned BitClks = 2 * MDC_DIV;
  localparam int unsigned GapClks = IDLE_BITS * BitClks;

  // One shared counter covers every timed phase, so size it for the longest one.
  localparam int unsigned MaxA    = (RESET_CYCLES > POST_RESET_CYCLES) ?
                                    RESET_CYCLES : POST_RESET_CYCLES;
  localparam int unsigned MaxB    = (GapClks > BitClks) ? GapClks : BitClks;
  localparam int unsigned CntMax  = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast  = CntW'(RESET_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(POST_RESET_CYCLES - 1);
  localparam logic [CntW-1:0] HighAt   = CntW'(MDC_DIV - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BitClks - 1);
  localparam logic [CntW-1:0] GapLast  = (GapClks == 0) ? '0 : CntW'(GapClks - 1);
  localparam logic [2:0]      LastEntry = 3'(NUM_WRITES - 1);

  // Padded to the 8-entry maximum so any 3-bit entry index stays in range.
  localparam logic [8*21-1:0] TablePad = (8 * 21)'(INIT_TABLE);

  typedef enum logic [2:0] {
    StRstHold,
    StRstWait,
    StShift,
    StGap,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;
  logic [2:0]      entry_q, entry_d;
  logic [63:0]     sh_q, sh_d;
  logic            resetn_q, resetn_d;
  logic            scl_q, scl_d;
  logic            done_q, done_d;

  logic [20:0]     entry_w;
  logic [63:0]     frame_w;

  // Frame for the current entry: preamble, ST=01, OP=01 (write), PHYAD, REGAD, TA=10, DATA.
  always_comb begin
    entry_w = TablePad[8'(entry_q) * 8'd21 +: 21];
    frame_w = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, entry_w[20:16], 2'b10, entry_w[15:0]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    entry_d  = entry_q;
    sh_d     = sh_q;
    resetn_d = resetn_q;
    scl_d    = scl_q;
    done_d   = done_q;

    unique case (state_q)
      StRstHold: begin
        resetn_d = 1'b0;
        scl_d    = 1'b0;
        sh_d     = '1;
        done_d   = 1'b0;
        entry_d  = '0;
        if (cnt_q == RstLast) begin
          cnt_d    = '0;
          resetn_d = 1'b1;
          state_d  = StRstWait;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StRstWait: begin
        if (cnt_q == WaitLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          sh_d    = frame_w;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StShift: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == HighAt) begin
          scl_d = 1'b1;
        end
        // End of a bit time: MDC drops and the next bit is presented in the same clock,
        // so MDIO is stable for the whole high phase. Ones shift in, leaving MDIO idle high.
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          scl_d = 1'b0;
          sh_d  = {sh_q[62:0], 1'b1};
          if (bit_q == 6'd63) begin
            if (entry_q == LastEntry) begin
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              entry_d = entry_q + 3'd1;
              state_d = StGap;
            end
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end

      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          sh_d    = frame_w;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        if (restart) begin
          cnt_d    = '0;
          entry_d  = '0;
          resetn_d = 1'b0;
          done_d   = 1'b0;
          state_d  = StRstHold;
        end
      end

      default: begin
        cnt_d    = '0;
        resetn_d = 1'b0;
        done_d   = 1'b0;
        state_d  = StRstHold;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StRstHold;
      cnt_q    <= '0;
      bit_q    <= '0;
      entry_q  <= '0;
      sh_q     <= '1;
      resetn_q <= 1'b0;
      scl_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      entry_q  <= entry_d;
      sh_q     <= sh_d;
      resetn_q <= resetn_d;
      scl_q    <= scl_d;
      done_q   <= done_d;
    end
  end

  assign phy_resetn    = resetn_q;
  assign mdio_scl      = scl_q;
  assign mdio_sda      = sh_q[63];
  assign phy_init_done = done_q;

endmodule

// File: tb/tb_phy_mdio_init.sv
module tb_phy_mdio_init;

  localparam logic [63:0] Frame0 = 64'hFFFF_FFFF_5082_1140; // 01 01 00001 00000 10 + 1140
  localparam logic [63:0] Frame1 = 64'hFFFF_FFFF_50FE_0000; // 01 01 00001 11111 10 + 0000

  localparam int KRstn  = 0;
  localparam int KFScl  = 1;
  localparam int KFrame = 2;
  localparam int KGap   = 3;
  localparam int KDone  = 4;
  localparam int KHold  = 5;

  typedef struct {
    int          kind;
    logic [63:0] val;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic restart = 1'b0;
  logic phy_resetn, mdio_scl, mdio_sda, phy_init_done;

  int total = 0;
  int bad = 0;
  int t = 0;
  ev_t exp_q[$];
  string knames[6] = '{"rstn_rise_t", "first_scl_t", "frame", "gap_clks", "done_rise_t",
                       "done_hold"};

  phy_mdio_init #(
    .RESET_CYCLES      (10),
    .POST_RESET_CYCLES (20),
    .MDC_DIV           (2),
    .IDLE_BITS         (8),
    .PHY_ADDR          (5'd1),
    .NUM_WRITES        (2),
    .INIT_TABLE        ({21'h1F_0000, 21'h00_1140})
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .restart       (restart),
    .phy_resetn    (phy_resetn),
    .mdio_scl      (mdio_scl),
    .mdio_sda      (mdio_sda),
    .phy_init_done (phy_init_done)
  );

  always #5 clock = ~clock;

  // Clocks elapsed in the current sequence; restarts at reset or an honoured restart.
  always @(posedge clock or posedge reset) begin
    if (reset) t <= 0;
    else if (restart && phy_init_done) t <= 0;
    else t <= t + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, req, t);
    end
  endtask

  task automatic push(input int kind, input logic [63:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_full();
    push(KRstn, 64'd10);
    push(KFScl, 64'd32);
    push(KFrame, Frame0);
    push(KGap, 64'd34);   // 32 idle clocks + low phase of the next frame's first bit
    push(KFrame, Frame1);
    push(KDone, 64'd574);
    push(KHold, 64'd1000);
  endtask

  task automatic emit(input int kind, input logic [63:0] act);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got %h expected nothing", knames[kind], act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== act) begin
        bad++;
        $display("FAIL %s: got %s=%h expected %s=%h", knames[e.kind], knames[kind], act,
                 knames[e.kind], e.val);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them against the queue.
  initial begin
    logic        p_rn, p_scl, p_sda, p_done;
    logic [63:0] word;
    int          nbits, gap_cnt, hold_cnt;
    bit          first, gap_on, hold_on;
    p_rn = 0; p_scl = 0; p_sda = 1; p_done = 0;
    word = '0; nbits = 0; gap_cnt = 0; hold_cnt = 0;
    first = 1; gap_on = 0; hold_on = 0;
    forever begin
      @(negedge clock);
      if (reset || (p_rn && !phy_resetn)) begin
        nbits = 0; first = 1; gap_on = 0; hold_on = 0;
      end
      if (!reset) begin
        if (!p_rn && phy_resetn) emit(KRstn, 64'(t));
        if (p_scl && mdio_scl) check("sda_stable_high", mdio_sda, p_sda);
        if (gap_on && !mdio_scl && mdio_sda) gap_cnt++;
        if (!p_scl && mdio_scl) begin
          if (first) begin
            emit(KFScl, 64'(t));
            first = 0;
          end
          if (gap_on) begin
            emit(KGap, 64'(gap_cnt));
            gap_on = 0;
          end
          word = {word[62:0], mdio_sda};
          nbits++;
          if (nbits == 64) begin
            emit(KFrame, word);
            nbits = 0; gap_on = 1; gap_cnt = 0;
          end
        end
        if (hold_on) begin
          if (phy_init_done && !mdio_scl && mdio_sda && phy_resetn) begin
            hold_cnt++;
            if (hold_cnt == 1000) begin
              emit(KHold, 64'(hold_cnt));
              hold_on = 0;
            end
          end else begin
            emit(KHold, 64'(hold_cnt));
            hold_on = 0;
          end
        end
        if (!p_done && phy_init_done) begin
          emit(KDone, 64'(t));
          gap_on = 0; hold_on = 1; hold_cnt = 0;
        end
      end
      p_rn = phy_resetn; p_scl = mdio_scl; p_sda = mdio_sda; p_done = phy_init_done;
    end
  end

  task automatic wait_t(input int target);
    int n = 0;
    while (t != target && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check("wait_t_reached", 64'(t), 64'(target));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_phy_resetn"}, 64'(phy_resetn), 64'd0);
    check({tag, "_scl"}, 64'(mdio_scl), 64'd0);
    check({tag, "_sda"}, 64'(mdio_sda), 64'd1);
    check({tag, "_done"}, 64'(phy_init_done), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals("por");

    // First run is cut short by an asynchronous reset in frame 0, bit 40 high phase.
    push(KRstn, 64'd10);
    push(KFScl, 64'd32);
    reset = 1'b0;
    wait_t(192);
    check("bit40_scl_high", 64'(mdio_scl), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    check("partial_run_events", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    @(negedge clock);

    // Clean run, with a restart pulse in SHIFT that must be ignored.
    push_full();
    reset = 1'b0;
    wait_t(100);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("restart_in_shift_resetn", 64'(phy_resetn), 64'd1);
    drain(3000);

    // Restart from DONE repeats the whole sequence.
    check("done_before_restart", 64'(phy_init_done), 64'd1);
    push_full();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("restart_done_drop", 64'(phy_init_done), 64'd0);
    check("restart_resetn_drop", 64'(phy_resetn), 64'd0);
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
